prog_load_ctrl: RTL and testbench
=================================

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 Parameters: MAX_CYCLES, 16'd1000, RUN-state cycle limit; CLR_CYCLES, 2, length of CPU reset pulse; DONE_ACTIVE, 1'b0, level of cpu_done that means "CPU halted".
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 clr  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid  in  1 / cmd_ready  out  1  command handshake; a command transfers on any edge where both are high.
REQ-005 cmd_type  in  2  00 write instr mem, 01 write data mem, 10 run, 11 abort; cmd_addr  in  16; cmd_data  in  16.
REQ-006 test_normal  out  1  memory-port owner select: 1 = loader, 0 = CPU.
REQ-007 ext_instr_we  out  1; ext_instr_addr  out  16; ext_instr_data  out  16  instruction-memory write port.
REQ-008 ext_data_we  out  1; ext_data_addr  out  16; ext_data_data  out  16  data-memory write port.
REQ-009 cpu_clr  out  1  CPU reset; cpu_done  in  1  CPU halt status; cpu_outr  in  16  CPU OutR.
REQ-010 out_valid  out  1 / out_ready  in  1 / out_data  out  16  captured-OutR stream, 4-entry FIFO.
REQ-011 busy, halted, timeout, overflow  out  1 each; cycle_count  out  16.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, CPU_RST, RUN, HALT; all outputs registered except cmd_ready and out_valid/out_data (from FIFO state).
REQ-013 cmd_ready SHALL be 1 in IDLE and HALT, 0 in LOAD and CPU_RST, and in RUN equal to (cmd_type==11).
REQ-014 Accepted write (00/01) in IDLE/HALT: next cycle enter LOAD, drive matching we=1 for exactly one cycle with cmd_addr/cmd_data; the other we stays 0; return to IDLE after that cycle.
REQ-015 ext_*_addr/data SHALL hold their last written values when we=0.
REQ-016 test_normal SHALL be 1 in IDLE and LOAD, 0 in CPU_RST, RUN, HALT.
REQ-017 Accepted run (10): enter CPU_RST; cpu_clr=1 for exactly CLR_CYCLES cycles; clear cycle_count, halted, timeout, overflow, FIFO; on leaving CPU_RST latch prev_outr=cpu_outr; enter RUN.
REQ-018 RUN: cycle_count increments by 1 per cycle, saturating at 16'hFFFF; busy=1 in LOAD, CPU_RST, RUN, else 0.
REQ-019 RUN: if cpu_done==DONE_ACTIVE -> HALT, halted=1 next cycle; if not done and cycle_count==MAX_CYCLES-1 -> HALT, timeout=1; done takes priority when both occur in one cycle.
REQ-020 RUN: each cycle where cpu_outr!=prev_outr SHALL push cpu_outr to FIFO and update prev_outr; repeated identical OUT values are not captured.
REQ-021 Push to full FIFO without simultaneous pop SHALL drop the value and set sticky overflow; push and pop in the same cycle when full both succeed.
REQ-022 out_valid = FIFO non-empty; pop on out_valid && out_ready; FIFO contents persist through HALT and IDLE until next run or reset.
REQ-023 Abort (11) accepted in RUN or HALT: next cycle IDLE, test_normal=1, halted=0, timeout=0; cpu_clr stays 0; FIFO retained. Abort in IDLE: no effect.
REQ-024 HALT: halted, timeout, cycle_count held; accepted write or run behaves as from IDLE and clears halted/timeout.

Reset
REQ-025 clr=1 at an edge SHALL force IDLE from any state (including mid-LOAD, mid-CPU_RST, RUN) and flush FIFO.
REQ-026 Reset values: test_normal=1, cpu_clr=0, both we=0, ext addr/data=0, busy=0, halted=0, timeout=0, overflow=0, cycle_count=0, out_valid=0.

Verification
REQ-027 Write data 0000<-0047, 0001<-0089 and 10 instr words (add-two-numbers program, HLT at 0009) -> exactly 12 one-cycle we pulses, correct addr/data, test_normal=1 throughout.
REQ-028 Run with CPU model outputting 0047, 0089, 00D0, 00D0 then done -> FIFO yields 0047, 0089, 00D0 (3 entries), halted=1, timeout=0, cpu_clr high exactly 2 cycles.
REQ-029 Run with MAX_CYCLES=20 and cpu_done never asserted -> HALT after 20 RUN cycles, timeout=1, cycle_count=20.
REQ-030 Five distinct OutR changes, out_ready=0 -> 4 entries retained in order, overflow=1; with out_ready=1 on the fifth push cycle -> all 5 delivered, overflow=0.
REQ-031 Abort command 5 cycles into RUN -> IDLE next cycle, test_normal=1, halted=0, captured entries still readable.
REQ-032 clr asserted during CPU_RST and during LOAD -> IDLE next cycle, cpu_clr=0, we=0, all REQ-026 values.

Source files
------------

// File: rtl/prog_load_ctrl_if.sv
// prog_load_ctrl_if -- host-side bus of the program loader.
//   cmd_*  : command channel (valid/ready); cmd_type 00 write instr mem, 01 write data mem,
//            10 run, 11 abort; cmd_addr/cmd_data carry the memory write.
//   out_*  : stream of captured CPU OutR values (valid/ready), fed from a 4-entry FIFO.
// Modports: master = host (test harness / UART bridge), slave = prog_load_ctrl.
interface prog_load_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_data, out_ready,
    input  cmd_ready, out_valid, out_data
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_data, out_ready,
    output cmd_ready, out_valid, out_data
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl -- loads a small CPU's instruction/data memories, runs it, and captures OutR.
// Ports:
//   i_clk, i_clr           clock and synchronous active-high reset
//   io_bus                 command channel and captured-OutR stream (prog_load_ctrl_if.slave)
//   o_test_normal          memory-port owner: 1 = loader, 0 = CPU
//   o_ext_instr_*          instruction-memory write port (we, addr, data)
//   o_ext_data_*           data-memory write port (we, addr, data)
//   o_cpu_clr              CPU reset pulse, CLR_CYCLES long at the start of each run
//   i_cpu_done, i_cpu_outr CPU halt status (active level DONE_ACTIVE) and OutR register
//   o_busy, o_halted, o_timeout, o_overflow, o_cycle_count   run status
module prog_load_ctrl #(
  parameter logic [15:0] MAX_CYCLES  = 16'd1000,
  parameter int unsigned CLR_CYCLES  = 2,
  parameter logic        DONE_ACTIVE = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_clr,
  prog_load_ctrl_if.slave        io_bus,
  output logic                   o_test_normal,
  output logic                   o_ext_instr_we,
  output logic [15:0]            o_ext_instr_addr,
  output logic [15:0]            o_ext_instr_data,
  output logic                   o_ext_data_we,
  output logic [15:0]            o_ext_data_addr,
  output logic [15:0]            o_ext_data_data,
  output logic                   o_cpu_clr,
  input  logic                   i_cpu_done,
  input  logic [15:0]            i_cpu_outr,
  output logic                   o_busy,
  output logic                   o_halted,
  output logic                   o_timeout,
  output logic                   o_overflow,
  output logic [15:0]            o_cycle_count
);

  localparam int unsigned ClrW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [ClrW-1:0] ClrLast = ClrW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCpuRst, StRun, StHalt} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [ClrW-1:0]   r_clr_cnt;
  logic [ClrW-1:0]   w_clr_cnt_d;

  logic              r_test_normal;
  logic              r_busy;
  logic              r_cpu_clr;
  logic              r_instr_we;
  logic [15:0]       r_instr_addr;
  logic [15:0]       r_instr_data;
  logic              r_data_we;
  logic [15:0]       r_data_addr;
  logic [15:0]       r_data_data;
  logic              r_halted;
  logic              r_timeout;
  logic              r_overflow;
  logic [15:0]       r_cycle_count;
  logic [15:0]       r_prev_outr;

  logic [15:0]       r_fifo [4];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_count;

  logic              w_cmd_ready;
  logic              w_wr_instr;
  logic              w_wr_data;
  logic              w_start;
  logic              w_abort;
  logic              w_run_step;
  logic              w_halt_done;
  logic              w_halt_to;
  logic              w_latch_prev;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_push_ok;
  logic [2:0]        w_count_d;

  // Next-state and command decode.
  always_comb begin
    w_state_d    = r_state;
    w_clr_cnt_d  = r_clr_cnt;
    w_cmd_ready  = 1'b0;
    w_wr_instr   = 1'b0;
    w_wr_data    = 1'b0;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_run_step   = 1'b0;
    w_halt_done  = 1'b0;
    w_halt_to    = 1'b0;
    w_latch_prev = 1'b0;
    unique case (r_state)
      StIdle, StHalt: begin
        w_cmd_ready = 1'b1;
        if (io_bus.cmd_valid) begin
          unique case (io_bus.cmd_type)
            2'b00: begin
              w_wr_instr = 1'b1;
              w_state_d  = StLoad;
            end
            2'b01: begin
              w_wr_data = 1'b1;
              w_state_d = StLoad;
            end
            2'b10: begin
              w_start     = 1'b1;
              w_clr_cnt_d = '0;
              w_state_d   = StCpuRst;
            end
            2'b11: begin
              // Abort only means something once a run has happened.
              if (r_state == StHalt) begin
                w_abort   = 1'b1;
                w_state_d = StIdle;
              end
            end
          endcase
        end
      end
      StLoad: w_state_d = StIdle;
      StCpuRst: begin
        if (r_clr_cnt == ClrLast) begin
          w_latch_prev = 1'b1;
          w_state_d    = StRun;
        end else begin
          w_clr_cnt_d = r_clr_cnt + ClrW'(1);
        end
      end
      StRun: begin
        // Only abort is accepted while the CPU owns the memories.
        w_cmd_ready = (io_bus.cmd_type == 2'b11);
        w_run_step  = 1'b1;
        if (io_bus.cmd_valid && w_cmd_ready) begin
          w_abort   = 1'b1;
          w_state_d = StIdle;
        end else if (i_cpu_done == DONE_ACTIVE) begin
          w_halt_done = 1'b1;
          w_state_d   = StHalt;
        end else if (r_cycle_count == MAX_CYCLES - 16'd1) begin
          w_halt_to = 1'b1;
          w_state_d = StHalt;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // OutR capture FIFO control. A push into a full FIFO still lands if a pop frees a slot.
  always_comb begin
    w_push    = w_run_step && (i_cpu_outr != r_prev_outr);
    w_pop     = (r_count != 3'd0) && io_bus.out_ready;
    w_full    = (r_count == 3'd4);
    w_push_ok = w_push && (!w_full || w_pop);
    w_count_d = r_count + {2'b00, w_push_ok} - {2'b00, w_pop};
  end

  // Control/status registers; outputs are registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state       <= StIdle;
      r_clr_cnt     <= '0;
      r_test_normal <= 1'b1;
      r_busy        <= 1'b0;
      r_cpu_clr     <= 1'b0;
      r_instr_we    <= 1'b0;
      r_instr_addr  <= 16'h0000;
      r_instr_data  <= 16'h0000;
      r_data_we     <= 1'b0;
      r_data_addr   <= 16'h0000;
      r_data_data   <= 16'h0000;
      r_halted      <= 1'b0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_cycle_count <= 16'h0000;
      r_prev_outr   <= 16'h0000;
    end else begin
      r_state       <= w_state_d;
      r_clr_cnt     <= w_clr_cnt_d;
      r_test_normal <= (w_state_d == StIdle) || (w_state_d == StLoad);
      r_busy        <= (w_state_d == StLoad) || (w_state_d == StCpuRst) || (w_state_d == StRun);
      r_cpu_clr     <= (w_state_d == StCpuRst);
      r_instr_we    <= w_wr_instr;
      r_data_we     <= w_wr_data;
      if (w_wr_instr) begin
        r_instr_addr <= io_bus.cmd_addr;
        r_instr_data <= io_bus.cmd_data;
      end
      if (w_wr_data) begin
        r_data_addr <= io_bus.cmd_addr;
        r_data_data <= io_bus.cmd_data;
      end

      // Any new command out of HALT (write, run, abort) drops the previous run's result flags.
      if (w_start || w_abort || w_wr_instr || w_wr_data) begin
        r_halted  <= 1'b0;
        r_timeout <= 1'b0;
      end else if (w_halt_done) begin
        r_halted <= 1'b1;
      end else if (w_halt_to) begin
        r_timeout <= 1'b1;
      end

      if (w_start) begin
        r_cycle_count <= 16'h0000;
      end else if (w_run_step && (r_cycle_count != 16'hFFFF)) begin
        r_cycle_count <= r_cycle_count + 16'd1;
      end

      if (w_start) begin
        r_overflow <= 1'b0;
      end else if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end

      if (w_latch_prev || w_push) begin
        r_prev_outr <= i_cpu_outr;
      end
    end
  end

  // FIFO pointers; flushed by reset and at the start of every run.
  always_ff @(posedge i_clk) begin
    if (i_clr || w_start) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_count <= w_count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_clr && !w_start) begin
      r_fifo[r_wr_ptr] <= i_cpu_outr;
    end
  end

  assign io_bus.cmd_ready = w_cmd_ready;
  assign io_bus.out_valid = (r_count != 3'd0);
  assign io_bus.out_data  = r_fifo[r_rd_ptr];

  assign o_test_normal    = r_test_normal;
  assign o_ext_instr_we   = r_instr_we;
  assign o_ext_instr_addr = r_instr_addr;
  assign o_ext_instr_data = r_instr_data;
  assign o_ext_data_we    = r_data_we;
  assign o_ext_data_addr  = r_data_addr;
  assign o_ext_data_data  = r_data_data;
  assign o_cpu_clr        = r_cpu_clr;
  assign o_busy           = r_busy;
  assign o_halted         = r_halted;
  assign o_timeout        = r_timeout;
  assign o_overflow       = r_overflow;
  assign o_cycle_count    = r_cycle_count;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: a queue-based model of the loader checked every cycle, plus
// hand-computed literal expectations at the key points of each directed scenario.
module tb_prog_load_ctrl;
  localparam logic [15:0] MaxCycles = 16'd20;
  localparam int          ClrCycles = 2;

  localparam int PIdle = 0;
  localparam int PLoad = 1;
  localparam int PRst  = 2;
  localparam int PRun  = 3;
  localparam int PHalt = 4;

  logic        clk;
  logic        clr;
  logic        test_normal;
  logic        instr_we;
  logic [15:0] instr_addr;
  logic [15:0] instr_data;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_data;
  logic        cpu_clr;
  logic        cpu_done;
  logic [15:0] cpu_outr;
  logic        busy;
  logic        halted;
  logic        timeout;
  logic        overflow;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_iwe    = 0;
  int n_dwe    = 0;
  int n_clr    = 0;
  int n_tn_low = 0;
  bit count_load = 1'b0;

  prog_load_ctrl_if bus_if ();

  prog_load_ctrl #(
    .MAX_CYCLES (MaxCycles),
    .CLR_CYCLES (ClrCycles),
    .DONE_ACTIVE(1'b0)
  ) dut (
    .i_clk           (clk),
    .i_clr           (clr),
    .io_bus          (bus_if),
    .o_test_normal   (test_normal),
    .o_ext_instr_we  (instr_we),
    .o_ext_instr_addr(instr_addr),
    .o_ext_instr_data(instr_data),
    .o_ext_data_we   (data_we),
    .o_ext_data_addr (data_addr),
    .o_ext_data_data (data_data),
    .o_cpu_clr       (cpu_clr),
    .i_cpu_done      (cpu_done),
    .i_cpu_outr      (cpu_outr),
    .o_busy          (busy),
    .o_halted        (halted),
    .o_timeout       (timeout),
    .o_overflow      (overflow),
    .o_cycle_count   (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_on = 1'b0;
  int          m_phase;
  int          m_rst_left;
  logic [15:0] m_count;
  bit          m_halted, m_timeout, m_ovf, m_iwe, m_dwe;
  logic [15:0] m_iaddr, m_idata, m_daddr, m_ddata, m_prev;
  logic [15:0] m_q[$];
  bit          acc, pop, lim;

  function automatic bit m_ready();
    if (m_phase == PIdle || m_phase == PHalt) return 1'b1;
    if (m_phase == PRun) return bus_if.cmd_type == 2'b11;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_on = 1'b1; m_phase = PIdle; m_rst_left = 0; m_count = 16'h0;
      m_halted = 0; m_timeout = 0; m_ovf = 0; m_iwe = 0; m_dwe = 0;
      m_iaddr = 0; m_idata = 0; m_daddr = 0; m_ddata = 0; m_prev = 0;
      m_q.delete();
    end else if (m_on) begin
      acc = bus_if.cmd_valid && m_ready();
      pop = (m_q.size() != 0) && bus_if.out_ready;
      m_iwe = 0;
      m_dwe = 0;
      if (pop) void'(m_q.pop_front());
      case (m_phase)
        PIdle, PHalt: if (acc) begin
          case (bus_if.cmd_type)
            2'b00: begin
              m_iwe = 1; m_iaddr = bus_if.cmd_addr; m_idata = bus_if.cmd_data;
              m_phase = PLoad; m_halted = 0; m_timeout = 0;
            end
            2'b01: begin
              m_dwe = 1; m_daddr = bus_if.cmd_addr; m_ddata = bus_if.cmd_data;
              m_phase = PLoad; m_halted = 0; m_timeout = 0;
            end
            2'b10: begin
              m_phase = PRst; m_rst_left = ClrCycles; m_count = 0;
              m_halted = 0; m_timeout = 0; m_ovf = 0; m_q.delete();
            end
            default: if (m_phase == PHalt) begin
              m_phase = PIdle; m_halted = 0; m_timeout = 0;
            end
          endcase
        end
        PLoad: m_phase = PIdle;
        PRst: begin
          m_rst_left--;
          if (m_rst_left == 0) begin
            m_prev = cpu_outr;
            m_phase = PRun;
          end
        end
        PRun: begin
          lim = (m_count == MaxCycles - 16'd1);
          if (cpu_outr != m_prev) begin
            m_prev = cpu_outr;
            if (m_q.size() < 4) m_q.push_back(cpu_outr);
            else m_ovf = 1;
          end
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          if (acc) begin
            m_phase = PIdle; m_halted = 0; m_timeout = 0;
          end else if (cpu_done == 1'b0) begin
            m_phase = PHalt; m_halted = 1;
          end else if (lim) begin
            m_phase = PHalt; m_timeout = 1;
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_on) begin
      check("test_normal", test_normal, (m_phase == PIdle) || (m_phase == PLoad));
      check("busy", busy, (m_phase == PLoad) || (m_phase == PRst) || (m_phase == PRun));
      check("cpu_clr", cpu_clr, m_phase == PRst);
      check("instr_we", instr_we, m_iwe);
      check("instr_addr", instr_addr, m_iaddr);
      check("instr_data", instr_data, m_idata);
      check("data_we", data_we, m_dwe);
      check("data_addr", data_addr, m_daddr);
      check("data_data", data_data, m_ddata);
      check("halted", halted, m_halted);
      check("timeout", timeout, m_timeout);
      check("overflow", overflow, m_ovf);
      check("cycle_count", cycle_count, m_count);
      check("cmd_ready", bus_if.cmd_ready, m_ready());
      check("out_valid", bus_if.out_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("out_data", bus_if.out_data, m_q[0]);
    end
  end

  always @(negedge clk) begin
    if (instr_we) n_iwe++;
    if (data_we) n_dwe++;
    if (cpu_clr) n_clr++;
    if (count_load && !test_normal) n_tn_low++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [15:0] a, input logic [15:0] d);
    bus_if.cmd_type  = t;
    bus_if.cmd_addr  = a;
    bus_if.cmd_data  = d;
    bus_if.cmd_valid = 1'b1;
    step(1);
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [15:0] val);
    check({name, "_valid"}, bus_if.out_valid, 1'b1);
    check(name, bus_if.out_data, val);
    bus_if.out_ready = 1'b1;
    step(1);
    bus_if.out_ready = 1'b0;
  endtask

  // Enter RUN (after the CPU reset pulse) with OutR parked at 0.
  task automatic start_run();
    cpu_outr = 16'h0000;
    n_clr = 0;
    send(2'b10, 16'h0, 16'h0);
    step(ClrCycles);
  endtask

  logic [15:0] prog [10];
  logic [15:0] seq4 [4];

  initial begin
    // Add-two-numbers program: load, add, store, output, halt (HLT at 0009).
    prog = '{16'h1000, 16'h2001, 16'h3002, 16'h4002, 16'h5000,
             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hF000};
    seq4 = '{16'h0047, 16'h0089, 16'h00D0, 16'h00D0};
    clr = 1'b1;
    cpu_done = 1'b1;
    cpu_outr = 16'h0000;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_type  = 2'b00;
    bus_if.cmd_addr  = 16'h0;
    bus_if.cmd_data  = 16'h0;
    bus_if.out_ready = 1'b0;
    step(2);
    clr = 1'b0;

    // Reset values.
    check("rst_test_normal", test_normal, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_cpu_clr", cpu_clr, 1'b0);
    check("rst_cycle_count", cycle_count, 16'd0);
    check("rst_out_valid", bus_if.out_valid, 1'b0);
    check("rst_instr_addr", instr_addr, 16'd0);

    // Program load: 2 data words + 10 instruction words.
    count_load = 1'b1;
    send(2'b01, 16'h0000, 16'h0047); step(1);
    send(2'b01, 16'h0001, 16'h0089); step(1);
    for (int i = 0; i < 10; i++) begin
      send(2'b00, 16'(i), prog[i]);
      step(1);
    end
    count_load = 1'b0;
    check("load_instr_pulses", n_iwe, 10);
    check("load_data_pulses", n_dwe, 2);
    check("load_test_normal_low", n_tn_low, 0);
    check("load_instr_addr_held", instr_addr, 16'h0009);
    check("load_instr_data_held", instr_data, 16'hF000);
    check("load_data_addr_held", data_addr, 16'h0001);
    check("load_data_data_held", data_data, 16'h0089);

    // Normal run: 0047, 0089, 00D0, 00D0, then done.
    start_run();
    for (int i = 0; i < 4; i++) begin
      cpu_outr = seq4[i];
      step(1);
    end
    cpu_done = 1'b0;
    step(1);
    cpu_done = 1'b1;
    check("run_halted", halted, 1'b1);
    check("run_timeout", timeout, 1'b0);
    check("run_cpu_clr_cycles", n_clr, 2);
    check("run_cycle_count", cycle_count, 16'd5);
    check("run_test_normal", test_normal, 1'b0);
    pop_expect("run_out0", 16'h0047);
    pop_expect("run_out1", 16'h0089);
    pop_expect("run_out2", 16'h00D0);
    check("run_fifo_empty", bus_if.out_valid, 1'b0);

    // Timeout: started from HALT, done never asserted.
    start_run();
    step(20);
    check("to_timeout", timeout, 1'b1);
    check("to_halted", halted, 1'b0);
    check("to_cycle_count", cycle_count, 16'd20);
    check("to_busy", busy, 1'b0);
    step(3);
    check("to_cycle_count_held", cycle_count, 16'd20);

    // Overflow: five changes, nobody popping.
    start_run();
    for (int v = 1; v <= 5; v++) begin
      cpu_outr = 16'(v);
      step(1);
    end
    cpu_done = 1'b0;
    step(1);
    cpu_done = 1'b1;
    check("ovf_overflow", overflow, 1'b1);
    for (int v = 1; v <= 4; v++) pop_expect("ovf_out", 16'(v));
    check("ovf_fifo_empty", bus_if.out_valid, 1'b0);

    // Same pattern with a pop alongside the fifth push.
    start_run();
    for (int v = 1; v <= 5; v++) begin
      cpu_outr = 16'(v);
      if (v == 5) begin
        bus_if.out_ready = 1'b1;
        check("full_popped_head", bus_if.out_data, 16'h0001);
      end
      step(1);
      bus_if.out_ready = 1'b0;
    end
    cpu_done = 1'b0;
    step(1);
    cpu_done = 1'b1;
    check("full_overflow", overflow, 1'b0);
    for (int v = 2; v <= 5; v++) pop_expect("full_out", 16'(v));

    // Abort 5 cycles into RUN.
    start_run();
    cpu_outr = 16'h0011; step(1);
    cpu_outr = 16'h0022; step(1);
    step(3);
    send(2'b11, 16'h0, 16'h0);
    check("abort_test_normal", test_normal, 1'b1);
    check("abort_halted", halted, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cpu_clr", cpu_clr, 1'b0);
    pop_expect("abort_out0", 16'h0011);
    // Abort while idle changes nothing.
    send(2'b11, 16'h0, 16'h0);
    check("idle_abort_busy", busy, 1'b0);
    check("idle_abort_out", bus_if.out_data, 16'h0022);

    // Reset in the middle of LOAD (FIFO still holds 0022).
    send(2'b00, 16'h00AA, 16'h1234);
    check("mid_load_we", instr_we, 1'b1);
    clr = 1'b1; step(1); clr = 1'b0;
    check("clr_load_we", instr_we, 1'b0);
    check("clr_load_addr", instr_addr, 16'h0000);
    check("clr_load_data_addr", data_addr, 16'h0000);
    check("clr_load_out_valid", bus_if.out_valid, 1'b0);
    check("clr_load_test_normal", test_normal, 1'b1);

    // Reset in the middle of CPU_RST.
    send(2'b10, 16'h0, 16'h0);
    check("mid_rst_cpu_clr", cpu_clr, 1'b1);
    clr = 1'b1; step(1); clr = 1'b0;
    check("clr_rst_cpu_clr", cpu_clr, 1'b0);
    check("clr_rst_busy", busy, 1'b0);
    check("clr_rst_test_normal", test_normal, 1'b1);
    step(4);
    check("clr_rst_stays_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
